alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational 32-bit datapath ALU.
- Keeps the existing opcode map. Adds:
  - a WIDTH parameter;
  - registered outputs with valid/ready flow control;
  - carry, overflow and illegal-op flags;
  - an iterative multi-cycle multiply.
- Sits between the decode/operand-fetch stage and writeback, so the core can stall on either side.

---
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add multiply,
// registered result with carry/overflow/illegal flags. WIDTH must be a power of two >= 8.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_MUL = 4'b0011,
    OP_SUB = 4'b0110,
    OP_LET = 4'b0111,
    OP_LSR = 4'b1000,
    OP_LSL = 4'b1001,
    OP_ASR = 4'b1010,
    OP_XOR = 4'b1101
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             illegal;
  } res_t;

  state_t           state;
  state_t           state_next;
  logic             armed;
  logic             accept;
  logic             is_mul;
  logic             mul_last;

  res_t             comb_res;
  res_t             out_q;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SW-1:0]    shamt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;

  // Ready is withheld until the first edge after reset release.
  assign in_ready  = armed && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && (alu_op == OP_MUL);
  assign mul_last  = (cnt == CW'(WIDTH - 1));
  assign out_valid = (state == S_DONE);

  assign result    = out_q.result;
  assign zero      = out_q.zero;
  assign carry     = out_q.carry;
  assign overflow  = out_q.overflow;
  assign illegal   = out_q.illegal;

  assign sum_ext   = {1'b0, op1} + {1'b0, op2};
  assign diff_ext  = {1'b0, op1} - {1'b0, op2};
  assign shamt     = op2[SW-1:0];
  assign acc_next  = acc + (mplr[0] ? mcand : '0);

  // Single-cycle result path; MUL (when enabled) bypasses this and uses the iterative datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    comb_res = '0;
    case (alu_op)
      OP_AND: comb_res.result = op1 & op2;
      OP_OR:  comb_res.result = op1 | op2;
      OP_XOR: comb_res.result = op1 ^ op2;
      OP_ADD: begin
        comb_res.result   = sum_ext[WIDTH-1:0];
        comb_res.carry    = sum_ext[WIDTH];
        comb_res.overflow = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        comb_res.result   = diff_ext[WIDTH-1:0];
        comb_res.carry    = ~diff_ext[WIDTH];
        comb_res.overflow = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_LET: comb_res.result = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_LSR: comb_res.result = op1 >> shamt;
      OP_LSL: comb_res.result = op1 << shamt;
      OP_ASR: comb_res.result = $unsigned($signed(op1) >>> shamt);
      OP_MUL: if (!MUL_EN) comb_res.illegal = 1'b1;
      default: comb_res.illegal = 1'b1;
    endcase
    comb_res.zero = ~|comb_res.result;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = is_mul ? S_BUSY : S_DONE;
      S_BUSY: if (mul_last) state_next = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (accept) state_next = is_mul ? S_BUSY : S_DONE;
          else        state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  // Result register and shift-add multiplier: one multiplier bit consumed per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so an aborted multiply leaves nothing behind.
    if (!rst_n) begin
      out_q <= '0;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand <= op1;
        mplr  <= op2;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        out_q <= comb_res;
      end
    end else if (state == S_BUSY) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
      if (mul_last) begin
        out_q.result   <= acc_next;
        out_q.zero     <= ~|acc_next;
        out_q.carry    <= 1'b0;
        out_q.overflow <= 1'b0;
        out_q.illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expectations queued on input transfer, compared on output transfer.
module tb_alu_seq;

  localparam int W = 32;
  localparam logic [3:0] OP_AND = 4'h0, OP_OR  = 4'h1, OP_ADD = 4'h2, OP_MUL = 4'h3,
                         OP_SUB = 4'h6, OP_LET = 4'h7, OP_LSR = 4'h8, OP_LSL = 4'h9,
                         OP_ASR = 4'hA, OP_XOR = 4'hD;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
    logic         i;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [3:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero, carry, overflow, illegal;

  logic         in_valid_b = 1'b0;
  logic         in_ready_b;
  logic         out_valid_b;
  logic         out_ready_b = 1'b1;
  logic [W-1:0] result_b;
  logic         zero_b, carry_b, overflow_b, illegal_b;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .result(result_b), .zero(zero_b), .carry(carry_b), .overflow(overflow_b), .illegal(illegal_b)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   n_pops = 0;
  int   n_ticks = 0;
  exp_t sb[$];
  exp_t exp_in;
  bit   last_accept;
  bit   rand_bp = 1'b0;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t            e;
    longint unsigned p;
    longint          s;
    e = '0;
    case (op)
      OP_AND: e.r = a & b;
      OP_OR:  e.r = a | b;
      OP_XOR: e.r = a ^ b;
      OP_ADD: begin
        p   = 64'(a) + 64'(b);
        e.r = p[31:0];
        e.c = p[32];
        s   = longint'($signed(a)) + longint'($signed(b));
        e.v = (s != longint'($signed(e.r)));
      end
      OP_SUB: begin
        e.r = a - b;
        e.c = (a >= b);
        s   = longint'($signed(a)) - longint'($signed(b));
        e.v = (s != longint'($signed(e.r)));
      end
      OP_MUL: begin
        p   = 64'(a) * 64'(b);
        e.r = p[31:0];
      end
      OP_LET: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_LSR: e.r = a >> b[4:0];
      OP_LSL: e.r = a << b[4:0];
      OP_ASR: e.r = 32'($signed(a) >>> b[4:0]);
      default: e.i = 1'b1;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // One clock: records input transfers into the scoreboard and checks output transfers against it.
  task automatic tick();
    exp_t e;
    exp_t got;
    @(negedge clk);
    last_accept = in_valid && in_ready;
    if (last_accept) sb.push_back(exp_in);
    if (out_valid && out_ready) begin
      got = {result, zero, carry, overflow, illegal};
      n_total++;
      n_pops++;
      if (sb.size() == 0) begin
        $display("FAIL sb_extra: got r=%h flags(zcvi)=%b with nothing expected", got.r, got[3:0]);
      end else begin
        e = sb.pop_front();
        if (got !== e)
          $display("FAIL sb_result: got r=%h zcvi=%b, expected r=%h zcvi=%b", got.r, got[3:0], e.r, e[3:0]);
        else
          n_pass++;
      end
    end
    @(posedge clk);
    #1;
    n_ticks++;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    alu_op   = op;
    op1      = a;
    op2      = b;
    exp_in   = e;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (last_accept) break;
    end
    n_total++;
    if (!last_accept) $display("FAIL send_timeout: op %h not accepted, got in_ready=%b expected 1", op, in_ready);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && (sb.size() != 0 || out_valid); k++) tick();
    n_total++;
    if (sb.size() != 0 || out_valid)
      $display("FAIL drain: got %0d pending results, out_valid=%b, expected 0 and 0", sb.size(), out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({out_valid, in_ready, result, zero, carry, overflow, illegal} !== '0)
      $display("FAIL reset_outputs: got valid=%b ready=%b r=%h zcvi=%b%b%b%b, expected all 0",
               out_valid, in_ready, result, zero, carry, overflow, illegal);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_release: got ready=%b valid=%b, expected ready=1 valid=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_shifts();
    send(OP_ASR, 32'h7FC3FFFF, 32'hFFFFFFF1, exp_t'({32'h00003FE1, 4'b0000}));
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL shift_latency: got out_valid=%b, expected 1", out_valid);
    else n_pass++;
    send(OP_LSR, 32'h7FC3FFFF, 32'hFFFFFFF1, exp_t'({32'h00003FE1, 4'b0000}));
    send(OP_LSL, 32'h7FC3FFFF, 32'hFFFFFFF1, exp_t'({32'hFFFE0000, 4'b0000}));
    send(OP_ASR, 32'h80000000, 32'h0000001F, exp_t'({32'hFFFFFFFF, 4'b0000}));
    drain();
  endtask

  task automatic test_flags();
    send(OP_ADD, 32'h7FFFFFFF, 32'h00000001, exp_t'({32'h80000000, 4'b0010}));
    send(OP_ADD, 32'hFFFFFFFF, 32'h00000001, exp_t'({32'h00000000, 4'b1100}));
    send(OP_SUB, 32'h00000005, 32'h00000007, exp_t'({32'hFFFFFFFE, 4'b0000}));
    send(OP_SUB, 32'h00000007, 32'h00000005, exp_t'({32'h00000002, 4'b0100}));
    send(OP_SUB, 32'h80000000, 32'h00000001, exp_t'({32'h7FFFFFFF, 4'b0110}));
    send(OP_LET, 32'hFFFFFFFF, 32'h00000001, exp_t'({32'h00000001, 4'b0000}));
    send(OP_LET, 32'h00000001, 32'hFFFFFFFF, exp_t'({32'h00000000, 4'b1000}));
    drain();
  endtask

  task automatic test_illegal();
    logic [3:0] bad_ops [5] = '{4'h5, 4'hB, 4'hC, 4'hE, 4'hF};
    send(4'h4, 32'h12345678, 32'h9ABCDEF0, exp_t'({32'h00000000, 4'b1001}));
    foreach (bad_ops[k]) send(bad_ops[k], $urandom, $urandom, model(bad_ops[k], 32'h1, 32'h2));
    drain();
  endtask

  task automatic test_mul();
    int lat;
    bit ready_seen;
    send(OP_MUL, 32'h0000FFFF, 32'h00010001, exp_t'({32'hFFFFFFFF, 4'b0000}));
    op1        = $urandom;
    op2        = $urandom;
    alu_op     = OP_AND;
    lat        = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      lat++;
    end
    n_total++;
    if (lat != 32) $display("FAIL mul_latency: got %0d cycles, expected 32", lat);
    else n_pass++;
    n_total++;
    if (ready_seen) $display("FAIL mul_busy_ready: got in_ready=1 during BUSY, expected 0");
    else n_pass++;
    drain();

    alu_op     = OP_MUL;
    op1        = 32'h0000FFFF;
    op2        = 32'h00010001;
    in_valid_b = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready_b !== 1'b1) $display("FAIL nomul_ready: got %b, expected 1", in_ready_b);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    n_total++;
    if ({out_valid_b, result_b, zero_b, carry_b, overflow_b, illegal_b} !== {1'b1, 32'h0, 4'b1001})
      $display("FAIL nomul_illegal: got valid=%b r=%h zcvi=%b%b%b%b, expected valid=1 r=0 zcvi=1001",
               out_valid_b, result_b, zero_b, carry_b, overflow_b, illegal_b);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int pops0;
    out_ready = 1'b0;
    send(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, exp_t'({32'hF000F000, 4'b0000}));
    alu_op   = OP_XOR;
    exp_in   = exp_t'({32'h0FF00FF0, 4'b0000});
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'hF000F000})
        $display("FAIL hold_%0d: got valid=%b ready=%b r=%h, expected 1 0 f000f000", k, out_valid, in_ready, result);
      else n_pass++;
      tick();
    end
    pops0     = n_pops;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({n_pops == pops0 + 1, last_accept, out_valid} !== 3'b111)
      $display("FAIL b2b_first: got pops=%0d accept=%b valid=%b, expected %0d 1 1",
               n_pops - pops0, last_accept, out_valid, 1);
    else n_pass++;
    tick();
    n_total++;
    if (n_pops != pops0 + 2) $display("FAIL b2b_second: got %0d transfers, expected 2", n_pops - pops0);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0]   fast_ops [9] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_LET, OP_LSR, OP_LSL, OP_ASR, OP_XOR};
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           t0;
    out_ready = 1'b1;
    t0 = n_ticks;
    for (int k = 0; k < 8; k++) begin
      op = fast_ops[$urandom_range(0, 8)];
      a  = $urandom;
      b  = $urandom;
      send(op, a, b, model(op, a, b));
    end
    n_total++;
    if (n_ticks - t0 != 8) $display("FAIL stream_rate: got %0d cycles for 8 ops, expected 8", n_ticks - t0);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    logic [W-1:0] corner [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h55555555};
    logic [3:0]   op;
    logic [W-1:0] a, b;
    rand_bp = 1'b1;
    for (int k = 0; k < 24; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      send(op, a, b, model(op, a, b));
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    bit stray;
    out_ready = 1'b1;
    send(OP_MUL, 32'h00000003, 32'h00000004, model(OP_MUL, 32'h3, 32'h4));
    repeat (9) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, in_ready, result} !== '0)
      $display("FAIL reset_async: got valid=%b ready=%b r=%h, expected 0 0 0", out_valid, in_ready, result);
    else n_pass++;
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) stray = 1'b1;
    end
    n_total++;
    if (stray) $display("FAIL reset_stray: got out_valid=1 after aborted MUL, expected 0");
    else n_pass++;
    send(OP_ADD, 32'd2, 32'd3, exp_t'({32'h00000005, 4'b0000}));
    drain();
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_flags();
    test_illegal();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

endmodule
